universal_reg_clr_pre: RTL and testbench



---
 rtl/universal_reg_clr_pre.sv | 86 ++++++++
 tb/tb_universal_reg_clr_pre.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/universal_reg_clr_pre.sv
// WIDTH-bit multi-mode register: async clear, sync preset, load/shift/rotate/toggle/count.
// Define UREG_COUNT_EN to build the up/down counter and its carry flag.
module universal_reg_clr_pre #(
   parameter int               WIDTH        = 8,
   parameter logic [WIDTH-1:0] PRESET_VALUE = {WIDTH{1'b1}}
) (
   input  logic             clock,
   input  logic             clear,
   input  logic             preset,
   input  logic             enable,
   input  logic [2:0]       mode,
   input  logic [WIDTH-1:0] d,
   input  logic             ser_in_l,
   input  logic             ser_in_r,
   output logic [WIDTH-1:0] q,
   output logic [WIDTH-1:0] q_bar,
   output logic             carry,
   output logic             zero
);

   logic [WIDTH-1:0] q_next;
   logic             carry_next;

`ifdef UREG_COUNT_EN
   localparam logic [WIDTH-1:0] ONE = WIDTH'(1);
`endif

   always_comb begin
      q_next     = q;
      carry_next = 1'b0;
      if (!preset) begin
         q_next = PRESET_VALUE;
      end else if (enable) begin
         unique case (mode)
            3'b000: q_next = q;
            3'b001: q_next = d;
            3'b010: q_next = {q[WIDTH-2:0], ser_in_r};
            3'b011: q_next = {ser_in_l, q[WIDTH-1:1]};
            3'b100: q_next = q ^ d;
            3'b101: q_next = {q[WIDTH-2:0], q[WIDTH-1]};
`ifdef UREG_COUNT_EN
            3'b110: begin
               q_next     = q + ONE;
               carry_next = (q == '1);
            end
            3'b111: begin
               q_next     = q - ONE;
               carry_next = (q == '0);
            end
`else
            3'b110, 3'b111: q_next = q;
`endif
         endcase
      end
   end

   always_ff @(posedge clock or negedge clear) begin
      if (!clear) begin
         q <= '0;
      end else begin
         q <= q_next;
      end
   end

`ifdef UREG_COUNT_EN
   logic carry_q;

   always_ff @(posedge clock or negedge clear) begin
      if (!clear) begin
         carry_q <= 1'b0;
      end else begin
         carry_q <= carry_next;
      end
   end

   assign carry = carry_q;
`else
   logic unused_carry;
   assign unused_carry = carry_next;
   assign carry        = 1'b0;
`endif

   assign q_bar = ~q;
   assign zero  = ~|q;

endmodule

// File: tb/tb_universal_reg_clr_pre.sv
// Scoreboard bench for universal_reg_clr_pre (WIDTH=8, PRESET_VALUE=8'hFF).
// Reference model uses integer arithmetic on the register value.
module tb_universal_reg_clr_pre;

   logic       clock = 1'b0;
   logic       clear = 1'b0;
   logic       preset = 1'b1;
   logic       enable = 1'b0;
   logic [2:0] mode = 3'b000;
   logic [7:0] d = 8'h00;
   logic       ser_in_l = 1'b0;
   logic       ser_in_r = 1'b0;
   logic [7:0] q;
   logic [7:0] q_bar;
   logic       carry;
   logic       zero;

   universal_reg_clr_pre #(
      .WIDTH(8),
      .PRESET_VALUE(8'hFF)
   ) dut (
      .clock(clock),
      .clear(clear),
      .preset(preset),
      .enable(enable),
      .mode(mode),
      .d(d),
      .ser_in_l(ser_in_l),
      .ser_in_r(ser_in_r),
      .q(q),
      .q_bar(q_bar),
      .carry(carry),
      .zero(zero)
   );

   always #5 clock = ~clock;

   typedef struct {
      int q;
      bit c;
   } exp_t;

   exp_t sb[$];
   event sample_ev;
   int   checks = 0;
   int   errors = 0;
   int   mq = 0;
   bit   driving_done = 1'b0;

   task automatic check(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s actual %0h required %0h", name, act, req);
      end
   endtask

   // Next state from the behavioural rules; returns {carry, q} packed as c*256+q
   function automatic int ref_next(input int cur, input bit p, input bit e,
                                   input int m, input int dd,
                                   input int sl, input int sr);
      int n;
      int c;
      n = cur;
      c = 0;
      if (!p) n = 255;
      else if (e) begin
         case (m)
            1: n = dd;
            2: n = (cur * 2 + sr) % 256;
            3: n = cur / 2 + sl * 128;
            4: n = cur ^ dd;
            5: n = (cur * 2) % 256 + cur / 128;
`ifdef UREG_COUNT_EN
            6: begin
               n = (cur + 1) % 256;
               c = (cur == 255) ? 1 : 0;
            end
            7: begin
               n = (cur + 255) % 256;
               c = (cur == 0) ? 1 : 0;
            end
`endif
            default: n = cur;
         endcase
      end
      return c * 256 + n;
   endfunction

   task automatic drive(input bit c, input bit p, input bit e,
                        input int m, input int dd,
                        input bit sl, input bit sr);
      exp_t x;
      int   r;
      clear    = c;
      preset   = p;
      enable   = e;
      mode     = 3'(m);
      d        = 8'(dd);
      ser_in_l = sl;
      ser_in_r = sr;
      if (!c) begin
         mq  = 0;
         x.q = 0;
         x.c = 1'b0;
         sb.push_back(x);
         ->sample_ev;
         sb.push_back(x);
      end else begin
         r   = ref_next(mq, p, e, m, dd, sl, sr);
         mq  = r % 256;
         x.q = mq;
         x.c = (r >= 256);
         sb.push_back(x);
      end
      @(negedge clock);
   endtask

   task automatic op(input int m, input int dd);
      drive(1'b1, 1'b1, 1'b1, m, dd, 1'b0, 1'b0);
   endtask

   initial begin : monitor
      exp_t x;
      forever begin
         @(posedge clock or sample_ev);
         #1;
         if (sb.size() > 0) begin
            x = sb.pop_front();
            check("q", int'(q), x.q);
            check("q_bar", int'(q_bar), (~x.q) & 255);
            check("zero", int'(zero), (x.q == 0) ? 1 : 0);
            check("carry", int'(carry), int'(x.c));
         end
      end
   end

   initial begin : watchdog
      #2_000_000;
      $display("FAIL watchdog actual timeout required finish");
      $fatal(1, "timeout");
   end

   initial begin : driver
      @(negedge clock);
      drive(1'b0, 1'b1, 1'b0, 0, 0, 1'b0, 1'b0);
      drive(1'b0, 1'b1, 1'b1, 1, 8'hAA, 1'b0, 1'b0);
      // async clear mid-cycle over a loaded value
      op(1, 8'h5A);
      op(0, 0);
      for (int i = 0; i < 3; i++)
         drive(1'b0, 1'b1, 1'b1, 1, 8'h33, 1'b0, 1'b0);
      // preset vs clear priority, preset over enable
      drive(1'b0, 1'b0, 1'b1, 1, 8'h11, 1'b0, 1'b0);
      drive(1'b1, 1'b0, 1'b1, 1, 8'h11, 1'b0, 1'b0);
      op(1, 8'h00);
      drive(1'b1, 1'b0, 1'b0, 1, 8'h22, 1'b0, 1'b0);
      // shift / rotate
      op(1, 8'h81);
      drive(1'b1, 1'b1, 1'b1, 2, 0, 1'b1, 1'b0);
      op(1, 8'h81);
      op(5, 0);
      op(1, 8'h81);
      drive(1'b1, 1'b1, 1'b1, 3, 0, 1'b1, 1'b0);
      // toggle
      op(1, 8'hF0);
      op(4, 8'h0F);
      op(4, 8'h0F);
      // count wrap (hold when counter is compiled out)
      op(1, 8'hFE);
      op(6, 0);
      op(6, 0);
      op(6, 0);
      op(1, 8'h00);
      op(7, 0);
      op(7, 0);
      op(1, 8'h12);
      for (int i = 0; i < 4; i++) op(6, 0);
      for (int i = 0; i < 300; i++) begin
         op(6, 0);
      end
      for (int i = 0; i < 600; i++) begin
         drive(($urandom_range(31) != 0), ($urandom_range(15) != 0),
               ($urandom_range(3) != 0), int'($urandom_range(7)),
               int'($urandom_range(255)), 1'($urandom), 1'($urandom));
      end
      op(0, 0);
      @(negedge clock);
      @(negedge clock);
      check("scoreboard_drain", sb.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
